// File: rtl/attack_projectiles.sv
// Multi-slot projectile generator: spawns, moves and expires projectiles on game
// frame ticks, and renders the lowest-index projectile covering the current pixel.
module attack_projectiles #(
  parameter int         NUM_SLOTS = 4,
  parameter int         SIZE      = 16,
  parameter int         SPEED     = 4,
  parameter int         RANGE     = 160,
  parameter int         COOLDOWN  = 8,
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [7:0] FIRE_KEY  = 8'd44
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 game_frame_clk_rising_edge,
  input  logic [7:0]           keycode,
  input  logic [8:0]           Player_X,
  input  logic [8:0]           Player_Y,
  input  logic [1:0]           Player_Direction,
  input  logic [8:0]           PixelX,
  input  logic [8:0]           PixelY,
  output logic                 is_obj,
  output logic [7:0]           Obj_address,
  output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] hit_slot,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 fire_pulse
);

  localparam int HW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [9:0]  SPEED_W = 10'(SPEED);
  localparam logic [9:0]  SIZE_W  = 10'(SIZE);
  localparam logic [9:0]  SCR_W   = 10'(SCREEN_W);
  localparam logic [9:0]  SCR_H   = 10'(SCREEN_H);
  localparam logic [10:0] RANGE_W = 11'(RANGE);

  logic [NUM_SLOTS-1:0] active_r, active_s;
  logic [8:0]           x_r    [NUM_SLOTS];
  logic [8:0]           x_s    [NUM_SLOTS];
  logic [8:0]           y_r    [NUM_SLOTS];
  logic [8:0]           y_s    [NUM_SLOTS];
  logic [1:0]           dir_r  [NUM_SLOTS];
  logic [1:0]           dir_s  [NUM_SLOTS];
  logic [9:0]           trav_r [NUM_SLOTS];
  logic [9:0]           trav_s [NUM_SLOTS];
  logic [CW-1:0]        cool_r, cool_s;
  logic                 fire_r, fire_s;

  logic [8:0]           spawn_x_s, spawn_y_s;
  logic                 spawn_ok_s;
  logic                 free_s;
  logic [HW-1:0]        free_idx_s;
  logic                 expire_s;
  logic [9:0]           x10_s, y10_s;
  logic [10:0]          trav_next_s;

  logic [NUM_SLOTS-1:0] hit_s;
  logic [7:0]           addr_s [NUM_SLOTS];
  logic [9:0]           ox_s, oy_s;
  logic [SW-1:0]        dx_s, dy_s;

  // Spawn point in front of the player; left/up spawns need room on screen.
  always_comb begin
    spawn_x_s  = Player_X + 9'd1;
    spawn_y_s  = Player_Y + 9'd20;
    spawn_ok_s = 1'b1;
    case (Player_Direction)
      2'd0: begin
        spawn_x_s  = Player_X + 9'd1;
        spawn_y_s  = Player_Y + 9'd20;
        spawn_ok_s = 1'b1;
      end
      2'd1: begin
        spawn_x_s  = Player_X - 9'(SIZE);
        spawn_y_s  = Player_Y + 9'd2;
        spawn_ok_s = (Player_X >= 9'(SIZE));
      end
      2'd2: begin
        spawn_x_s  = Player_X + 9'd1;
        spawn_y_s  = Player_Y - 9'(SIZE);
        spawn_ok_s = (Player_Y >= 9'(SIZE));
      end
      2'd3: begin
        spawn_x_s  = Player_X + 9'd18;
        spawn_y_s  = Player_Y + 9'd2;
        spawn_ok_s = 1'b1;
      end
      default: begin
        spawn_x_s  = Player_X + 9'd1;
        spawn_y_s  = Player_Y + 9'd20;
        spawn_ok_s = 1'b1;
      end
    endcase
  end

  // Lowest-index slot that is free at the start of the tick.
  always_comb begin
    free_s     = 1'b0;
    free_idx_s = {HW{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s = active_r[i] ? free_idx_s : HW'(i);
      free_s     = free_s | ~active_r[i];
    end
  end

  // Frame-tick update: move or expire every active slot, then maybe spawn.
  always_comb begin
    active_s    = active_r;
    x_s         = x_r;
    y_s         = y_r;
    dir_s       = dir_r;
    trav_s      = trav_r;
    cool_s      = cool_r;
    fire_s      = 1'b0;
    expire_s    = 1'b0;
    x10_s       = 10'd0;
    y10_s       = 10'd0;
    trav_next_s = 11'd0;
    if (game_frame_clk_rising_edge) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x10_s       = {1'b0, x_r[i]};
        y10_s       = {1'b0, y_r[i]};
        trav_next_s = {1'b0, trav_r[i]} + 11'(SPEED);
        case (dir_r[i])
          2'd0:    expire_s = (y10_s + SPEED_W + SIZE_W) > SCR_H;
          2'd1:    expire_s = x10_s < SPEED_W;
          2'd2:    expire_s = y10_s < SPEED_W;
          2'd3:    expire_s = (x10_s + SPEED_W + SIZE_W) > SCR_W;
          default: expire_s = 1'b0;
        endcase
        expire_s = expire_s | (trav_next_s > RANGE_W);
        if (!active_r[i]) begin
          active_s[i] = 1'b0;
        end else if (expire_s) begin
          active_s[i] = 1'b0;
        end else begin
          trav_s[i] = trav_next_s[9:0];
          case (dir_r[i])
            2'd0:    y_s[i] = y_r[i] + 9'(SPEED);
            2'd1:    x_s[i] = x_r[i] - 9'(SPEED);
            2'd2:    y_s[i] = y_r[i] - 9'(SPEED);
            2'd3:    x_s[i] = x_r[i] + 9'(SPEED);
            default: x_s[i] = x_r[i];
          endcase
        end
      end
      // A blocked shot (no slot / bad spawn point) leaves the cooldown untouched.
      if ((keycode == FIRE_KEY) && (cool_r == {CW{1'b0}}) && free_s && spawn_ok_s) begin
        active_s[free_idx_s] = 1'b1;
        x_s[free_idx_s]      = spawn_x_s;
        y_s[free_idx_s]      = spawn_y_s;
        dir_s[free_idx_s]    = Player_Direction;
        trav_s[free_idx_s]   = 10'd0;
        cool_s               = CW'(COOLDOWN);
        fire_s               = 1'b1;
      end else if (cool_r != {CW{1'b0}}) begin
        cool_s = cool_r - CW'(1);
      end else begin
        cool_s = cool_r;
      end
    end else begin
      fire_s = 1'b0;
    end
  end

  // State registers; Reset wins over a coincident frame tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_r <= {NUM_SLOTS{1'b0}};
      cool_r   <= {CW{1'b0}};
      fire_r   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_r[i]    <= 9'd0;
        y_r[i]    <= 9'd0;
        dir_r[i]  <= 2'd0;
        trav_r[i] <= 10'd0;
      end
    end else begin
      active_r <= active_s;
      cool_r   <= cool_s;
      fire_r   <= fire_s;
      x_r      <= x_s;
      y_r      <= y_s;
      dir_r    <= dir_s;
      trav_r   <= trav_s;
    end
  end

  // Per-slot hit test and sprite address, mirrored for left/up travel.
  always_comb begin
    ox_s = 10'd0;
    oy_s = 10'd0;
    dx_s = {SW{1'b0}};
    dy_s = {SW{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ox_s      = {1'b0, PixelX} - {1'b0, x_r[i]};
      oy_s      = {1'b0, PixelY} - {1'b0, y_r[i]};
      hit_s[i]  = active_r[i] && (PixelX >= x_r[i]) && (ox_s < SIZE_W) &&
                  (PixelY >= y_r[i]) && (oy_s < SIZE_W);
      dx_s      = (dir_r[i] == 2'd1) ? (SW'(SIZE - 1) - SW'(ox_s)) : SW'(ox_s);
      dy_s      = (dir_r[i] == 2'd2) ? (SW'(SIZE - 1) - SW'(oy_s)) : SW'(oy_s);
      addr_s[i] = 8'({dy_s, dx_s});
    end
  end

  // Priority select: scanning downwards lets the lowest hitting index win.
  always_comb begin
    is_obj      = 1'b0;
    Obj_address = 8'd0;
    hit_slot    = {HW{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      is_obj      = is_obj | hit_s[i];
      Obj_address = hit_s[i] ? addr_s[i] : Obj_address;
      hit_slot    = hit_s[i] ? HW'(i) : hit_slot;
    end
  end

  assign active_mask = active_r;
  assign fire_pulse  = fire_r;

endmodule
